// File: rtl/ne16_ctrl_loop_nest.sv
// NE16 loop-nest sequencer: walks an NB_LEVELS-deep iteration space (level 0 innermost),
// emitting one index tuple per valid/ready handshake and pulsing done_o at the end of a job.
module ne16_ctrl_loop_nest #(
    parameter int unsigned BITS      = 16,
    parameter int unsigned NB_LEVELS = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      test_mode_i,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic [NB_LEVELS*BITS-1:0] limit_i,
    output logic                      step_valid_o,
    input  logic                      step_ready_i,
    output logic [NB_LEVELS*BITS-1:0] index_o,
    output logic [NB_LEVELS-1:0]      last_o,
    output logic                      busy_o,
    output logic                      done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [BITS-1:0] lim_q [NB_LEVELS];
    logic [BITS-1:0] idx_q [NB_LEVELS];
    logic [BITS-1:0] lim_in [NB_LEVELS];
    logic            any_zero;
    logic [NB_LEVELS:0] carry;
    logic            handshake;
    logic            valid_q, busy_q, done_q;
    logic            unused_test_mode;

    assign unused_test_mode = test_mode_i;

    always_comb begin
        any_zero = 1'b0;
        for (int unsigned l = 0; l < NB_LEVELS; l++) begin
            lim_in[l] = limit_i[l*BITS +: BITS];
            if (lim_in[l] == '0) any_zero = 1'b1;
        end
    end

    // carry[l] means every level below l is at its last index; carry[NB_LEVELS] ends the job.
    always_comb begin
        last_o   = '0;
        index_o  = '0;
        carry    = '0;
        carry[0] = 1'b1;
        for (int unsigned l = 0; l < NB_LEVELS; l++) begin
            last_o[l]             = (idx_q[l] == lim_q[l] - 1'b1);
            index_o[l*BITS +: BITS] = idx_q[l];
            carry[l+1]            = carry[l] & last_o[l];
        end
    end

    assign handshake    = valid_q & step_ready_i;
    assign step_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned l = 0; l < NB_LEVELS; l++) begin
                lim_q[l] <= '0;
                idx_q[l] <= '0;
            end
        end else if (clear_i) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned l = 0; l < NB_LEVELS; l++) begin
                lim_q[l] <= '0;
                idx_q[l] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        for (int unsigned l = 0; l < NB_LEVELS; l++) begin
                            lim_q[l] <= lim_in[l];
                            idx_q[l] <= '0;
                        end
                        busy_q <= 1'b1;
                        if (any_zero) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            valid_q <= 1'b0;
                        end else begin
                            state   <= RUN;
                            valid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        for (int unsigned l = 0; l < NB_LEVELS; l++) begin
                            if (carry[l]) idx_q[l] <= last_o[l] ? '0 : idx_q[l] + 1'b1;
                        end
                        if (carry[NB_LEVELS]) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ne16_ctrl_loop_nest.sv
// Self-checking bench for ne16_ctrl_loop_nest: a mixed-radix model fills a scoreboard of
// expected index tuples, popped and compared on every observed handshake.
module tb_ne16_ctrl_loop_nest;

    localparam int unsigned BITS = 4;
    localparam int unsigned NL   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 test_mode;
    logic                 clear;
    logic                 start;
    logic [NL*BITS-1:0]   limit;
    logic                 step_valid;
    logic                 step_ready;
    logic [NL*BITS-1:0]   index;
    logic [NL-1:0]        last;
    logic                 busy;
    logic                 done;

    typedef struct packed {
        logic [NL*BITS-1:0] idx;
        logic [NL-1:0]      last;
    } step_t;

    step_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    ne16_ctrl_loop_nest #(.BITS(BITS), .NB_LEVELS(NL)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .test_mode_i  (test_mode),
        .clear_i      (clear),
        .start_i      (start),
        .limit_i      (limit),
        .step_valid_o (step_valid),
        .step_ready_i (step_ready),
        .index_o      (index),
        .last_o       (last),
        .busy_o       (busy),
        .done_o       (done)
    );

    function automatic logic [NL*BITS-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [NL*BITS-1:0] r;
        int t[NL];
        t = '{a, b, c, d};
        r = '0;
        for (int l = 0; l < NL; l++) r[l*BITS +: BITS] = t[l][BITS-1:0];
        return r;
    endfunction

    // Expected tuple n is the mixed-radix decomposition of n with level 0 as least significant digit.
    task automatic push_job(input int l0, input int l1, input int l2, input int l3);
        int    lims[NL];
        int    total, div, v;
        step_t s;
        lims  = '{l0, l1, l2, l3};
        total = l0 * l1 * l2 * l3;
        for (int n = 0; n < total; n++) begin
            div = 1;
            s   = '0;
            for (int l = 0; l < NL; l++) begin
                v = (n / div) % lims[l];
                s.idx[l*BITS +: BITS] = v[BITS-1:0];
                s.last[l] = (v == lims[l] - 1);
                div = div * lims[l];
            end
            exp_q.push_back(s);
        end
    endtask

    task automatic start_job(input int l0, input int l1, input int l2, input int l3);
        @(negedge clk);
        limit = pack4(l0, l1, l2, l3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_idle(input string name);
        tests++;
        if (busy !== 1'b0 || step_valid !== 1'b0 || done !== 1'b0 || index !== '0) begin
            fails++;
            $display("FAIL %s: busy=%b valid=%b done=%b index=%h, required 0 0 0 0", name, busy, step_valid, done, index);
        end
    endtask

    // Drives ready and checks each RUN cycle; returns on done_o, or early once clear_at steps are taken.
    task automatic run_steps(input int pct, input int poke_at, input int clear_at,
                             input int max_cycles, output int nsteps);
        logic               prev_hs, have_prev, finished;
        logic [NL*BITS-1:0] prev_idx;
        step_t              e;
        nsteps    = 0;
        prev_hs   = 1'b0;
        have_prev = 1'b0;
        finished  = 1'b0;
        prev_idx  = '0;
        for (int cyc = 0; cyc < max_cycles && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == poke_at) begin
                start = 1'b1;
                limit = pack4(2, 3, 5, 7);
            end
            if (done === 1'b1) begin
                finished = 1'b1;
                tests++;
                if (!prev_hs || exp_q.size() != 0 || step_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL done_timing: prev_handshake=%b pending=%0d valid=%b, required 1 0 0",
                             prev_hs, exp_q.size(), step_valid);
                end
            end else begin
                tests++;
                if (step_valid !== 1'b1 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL valid_stable: valid=%b busy=%b, required 1 1", step_valid, busy);
                end
                if (have_prev && !prev_hs) begin
                    tests++;
                    if (index !== prev_idx) begin
                        fails++;
                        $display("FAIL index_hold: index=%h, required %h", index, prev_idx);
                    end
                end
                if (clear_at >= 0 && nsteps == clear_at) begin
                    step_ready = 1'b0;
                    finished   = 1'b1;
                end else begin
                    step_ready = ($urandom_range(99) < pct);
                    prev_hs    = step_valid & step_ready;
                    prev_idx   = index;
                    have_prev  = 1'b1;
                    if (prev_hs) begin
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL extra_step: index=%h, required no step", index);
                        end else begin
                            e = exp_q.pop_front();
                            if (index !== e.idx || last !== e.last) begin
                                fails++;
                                $display("FAIL step_%0d: index=%h last=%b, required index=%h last=%b",
                                         nsteps, index, last, e.idx, e.last);
                            end
                        end
                        nsteps++;
                    end
                end
            end
        end
        if (!finished) begin
            tests++;
            fails++;
            $display("FAIL timeout: no done_o within %0d cycles", max_cycles);
        end
        if (clear_at < 0) step_ready = 1'b0;
    endtask

    task automatic check_count(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s_count: steps=%0d, required %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset_state");
        tests++;
        if (last !== '0) begin
            fails++;
            $display("FAIL reset_last: last=%b, required 0000", last);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        push_job(2, 3, 1, 1);
        start_job(2, 3, 1, 1);
        run_steps(100, -1, -1, 100, n);
        check_count("basic", n, 6);
    endtask

    task automatic test_backpressure();
        int n;
        push_job(3, 2, 1, 1);
        start_job(3, 2, 1, 1);
        run_steps(50, -1, -1, 300, n);
        check_count("backpressure", n, 6);
    endtask

    task automatic test_degenerate();
        int n;
        push_job(1, 1, 1, 1);
        start_job(1, 1, 1, 1);
        run_steps(100, -1, -1, 20, n);
        check_count("all_ones", n, 1);
        start_job(1, 1, 0, 1);
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || step_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL zero_limit_done: done=%b valid=%b busy=%b, required 1 0 1", done, step_valid, busy);
        end
        @(negedge clk);
        check_idle("zero_limit_after");
    endtask

    task automatic test_start_during_run();
        int n;
        push_job(4, 4, 1, 1);
        start_job(4, 4, 1, 1);
        run_steps(100, 7, -1, 100, n);
        check_count("start_during_run", n, 16);
    endtask

    task automatic test_clear();
        int n;
        push_job(4, 4, 1, 1);
        start_job(4, 4, 1, 1);
        run_steps(100, -1, 5, 100, n);
        check_count("clear_prefix", n, 5);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check_idle("clear_state");
        @(negedge clk);
        check_idle("clear_no_done");
        exp_q.delete();
        push_job(4, 4, 1, 1);
        start_job(4, 4, 1, 1);
        run_steps(100, -1, -1, 100, n);
        check_count("after_clear", n, 16);
    endtask

    task automatic test_reset_mid_run();
        int n;
        push_job(4, 4, 1, 1);
        start_job(4, 4, 1, 1);
        run_steps(100, -1, 5, 100, n);
        rst_n = 1'b0;
        #1;
        check_idle("async_reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_no_done");
        exp_q.delete();
        push_job(4, 4, 1, 1);
        start_job(4, 4, 1, 1);
        run_steps(100, -1, -1, 100, n);
        check_count("after_reset", n, 16);
    endtask

    task automatic test_wide();
        int n;
        push_job(15, 2, 1, 1);
        start_job(15, 2, 1, 1);
        run_steps(100, -1, -1, 100, n);
        check_count("wide", n, 30);
    endtask

    // start_i held from the done_o cycle: ignored in DONE, accepted once back in IDLE.
    task automatic test_back_to_back();
        int n;
        push_job(2, 2, 1, 1);
        start_job(2, 2, 1, 1);
        run_steps(100, -1, -1, 100, n);
        check_count("b2b_first", n, 4);
        limit = pack4(2, 3, 1, 1);
        start = 1'b1;
        @(negedge clk);
        check_idle("b2b_idle_gap");
        @(posedge clk);
        #1 start = 1'b0;
        push_job(2, 3, 1, 1);
        run_steps(100, -1, -1, 100, n);
        check_count("b2b_second", n, 6);
    endtask

    initial begin
        test_mode  = 1'b0;
        clear      = 1'b0;
        start      = 1'b0;
        step_ready = 1'b0;
        limit      = '0;
        rst_n      = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_degenerate();
        test_start_during_run();
        test_clear();
        test_reset_mid_run();
        test_wide();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ne16_ctrl_loop_nest.md
# ne16_ctrl_loop_nest

Multi-level loop-nest sequencer for the NE16 controller. On `start_i` it latches per-level iteration limits and walks the full iteration space, innermost level first. It emits one index tuple per valid/ready step to the datapath sequencer, then pulses `done_o`. All counters and limits are registered, so the wrap/last flags are computed from flops only and never from the handshake.

## Interface
Parameters:
- `BITS`, 16: width of each level's counter and limit.
- `NB_LEVELS`, 4: number of nested levels; level 0 is innermost.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `test_mode_i`  in  1  test mode; no functional effect.
- `clear_i`  in  1  synchronous soft clear; forces IDLE and zeroes all state.
- `start_i`  in  1  start request; sampled only in IDLE.
- `limit_i`  in  NB_LEVELS×BITS  iteration count per level; sampled only when `start_i` is accepted.
- `step_valid_o`  out  1  current index tuple is valid.
- `step_ready_i`  in  1  datapath accepts the current tuple.
- `index_o`  out  NB_LEVELS×BITS  current index per level.
- `last_o`  out  NB_LEVELS  level l is at `limit-1` (combinational from registered state).
- `busy_o`  out  1  FSM is in RUN or DONE.
- `done_o`  out  1  one-cycle pulse at the end of a job.

## Operation
- **FSM states**: IDLE, RUN, DONE.
- **IDLE**
  - `start_i`=1 latches `limit_i` into `lim_q` and clears all indices.
  - If any latched limit is 0, go to DONE and issue no steps.
  - Otherwise go to RUN.
- **RUN**
  - `step_valid_o`=1.
  - A handshake (valid & ready) advances the nest:
    - Level 0 increments.
    - Level l increments only if every level below it has `last_o`=1.
    - Any level with `last_o`=1 that receives a carry wraps to 0.
  - A handshake with all `last_o`=1 goes to DONE; indices wrap to all-zero.
  - With no handshake, indices hold. `step_valid_o` never drops while in RUN.
- **DONE**: `done_o`=1 for exactly one cycle, then IDLE.
- **`start_i` outside IDLE**: ignored; it is neither queued nor relatched.
- **`limit_i` changes after start**: ignored until the next accepted start.
- **Arithmetic**
  - `last_o[l]` = (`idx_q[l]` == `lim_q[l]`-1), computed in BITS bits.
  - A limit of 1 means `last_o` is always 1 at that level.
  - The maximum limit 2^BITS-1 gives indices 0..2^BITS-2.
  - A limit of 0 never reaches `last_o` evaluation because the job goes straight to DONE.
- **Total steps per job**: product of the limits.
- **`clear_i`**
  - Takes priority over `start_i` and the handshake in every state.
  - Next cycle: IDLE, indices 0, limits 0, no `done_o`.
- **Asynchronous reset**: same resulting state as `clear_i`.
- **Reset values**: `step_valid_o`=0, `index_o`=0, `busy_o`=0, `done_o`=0. `last_o` equals 0 because `lim_q`=0 makes `limit-1` all-ones. `last_o` is don't-care outside RUN.

## Timing
- Start accepted at edge 0 → `step_valid_o`=1 and `index_o`=0 from cycle 1.
- One step per cycle maximum; with ready held high, steps are back-to-back.
- Index update latency: the handshake at edge n gives the new `index_o` from cycle n+1.
- Final handshake at edge n → `done_o`=1 in cycle n+1, IDLE in cycle n+2.
  - The next `start_i` is accepted at the earliest on edge n+2.
- Zero-limit start at edge 0 → `done_o` in cycle 1; `step_valid_o` never asserts.
- `busy_o` is high from cycle 1 through the `done_o` cycle inclusive.
- Critical path: the compare of a registered index against a registered limit, plus the carry chain through NB_LEVELS AND terms. There is no input-to-output combinational path except `step_ready_i` into next-state logic.

## Test plan
- **Basic nest**
  - Stimulus: limits {2,3,1,1} (L0..L3), ready held high.
  - Required response: exactly 6 steps.
  - (L0,L1) sequence: (0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
  - `last_o[0]` toggles 0,1 on alternate steps.
  - `done_o` occurs one cycle after the 6th handshake.
- **Backpressure**
  - Stimulus: limits {3,2,1,1}, ready random at 50%.
  - Required response: indices change only on handshake cycles; `step_valid_o` is stable high; the step count is 6.
- **Degenerate limits**
  - All limits = 1 → one step with `index_o`=0 and all `last_o`=1, then `done_o`.
  - `limit[2]`=0 → no `step_valid_o`; `done_o` in cycle 1.
- **Start during run**
  - Stimulus: pulse `start_i` with different `limit_i` in the middle of a job with limits {4,4,1,1}.
  - Required response: the sequence is unchanged; 16 steps total.
- **Clear / reset mid-run**
  - Stimulus: `clear_i` after step 5 of a 16-step job.
  - Required response: next cycle `busy_o`=0, `index_o`=0, no `done_o`.
  - A new start runs the full job.
  - Asserting `rst_ni` low mid-run gives the same result.
- **Wide limit**
  - Stimulus: BITS=4, limits {15,2,1,1}.
  - Required response: L0 runs 0..14 and then wraps to 0 with L1 incrementing; 30 steps; no overflow to 15.
